// File: rtl/tick_bcd_counter_pkg.sv
// Shared types and constants for the ena-tick BCD counter.
// Holds the run-control state encoding, digit width and the packed status payload.
package tick_bcd_counter_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    typedef struct packed {
        logic running;
        logic wrap;
        logic overflow;
    } status_t;

endpackage

// File: rtl/tick_bcd_counter_bcd_digit.sv
// One BCD digit of the tick counter: 0..9 register with synchronous clear and ripple carry.
module tick_bcd_counter_bcd_digit
    import tick_bcd_counter_pkg::*;
(
    input  logic               div_clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [DIGIT_W-1:0] q,
    output logic               at_max,
    output logic               carry
);

    assign at_max = (q == BCD_MAX);
    assign carry  = inc & at_max;

    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= at_max ? '0 : q + DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/tick_bcd_counter.sv
// Counts divider enable ticks in a DIGITS-wide BCD register under start/stop/clear control.
// Outputs packed BCD plus registered running/wrap/overflow status for the readout stage.
module tick_bcd_counter
    import tick_bcd_counter_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                        div_clk,
    input  logic                        reset,
    input  logic                        ena,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        clear,
    output logic [DIGIT_W*DIGITS-1:0]   bcd,
    output logic                        running,
    output logic                        wrap,
    output logic                        overflow
);

    state_t            state;
    state_t            state_nxt;
    status_t           status;
    status_t           status_nxt;
    logic [DIGITS:0]   inc_chain;
    logic [DIGITS-1:0] at_max;
    logic              all_max;
    logic              tick;
    logic              wrap_evt;
    logic              sat_evt;

    // A tick is only taken from the registered RUN state with no clear/stop pending.
    always_comb begin
        tick     = (state == ST_RUN) & ena & ~clear & ~stop;
        all_max  = &at_max;
        sat_evt  = tick & all_max & SATURATE;
        wrap_evt = inc_chain[DIGITS];
    end

    // Saturating mode blocks the increment at max so the carry chain never rolls over.
    assign inc_chain[0] = tick & ~sat_evt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        tick_bcd_counter_bcd_digit u_digit (
            .div_clk (div_clk),
            .reset   (reset),
            .inc     (inc_chain[g]),
            .clr     (clear),
            .q       (bcd[g*DIGIT_W +: DIGIT_W]),
            .at_max  (at_max[g]),
            .carry   (inc_chain[g+1])
        );
    end

    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            status <= '0;
        end else begin
            state  <= state_nxt;
            status <= status_nxt;
        end
    end

    // Run control: clear beats stop, stop beats start.
    always_comb begin
        state_nxt  = state;
        status_nxt = '0;

        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (start && !stop) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop || sat_evt) begin
                        state_nxt = ST_HOLD;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        status_nxt.running  = (state_nxt == ST_RUN);
        status_nxt.wrap     = wrap_evt;
        status_nxt.overflow = ~clear & (status.overflow | wrap_evt | sat_evt);
    end

    assign running  = status.running;
    assign wrap     = status.wrap;
    assign overflow = status.overflow;

endmodule
